inst_prefetch_buffer: RTL and testbench

Instruction fetch front end that sits directly upstream of the MIPS core's instruction input. It issues word fetches to a variable-latency instruction memory over a valid/ready request channel with at most one request outstanding. Returned words are queued with their PCs in a small FIFO and presented to the core over a valid/ready channel. Branch/jump redirects from the core flush the queue and any in-flight fetch.

---
 rtl/inst_prefetch_buffer.sv | 160 ++++++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_buffer.sv
// ============================================================================
// Module   : inst_prefetch_buffer
// Function : Instruction fetch front end. It keeps one request outstanding and
//            queues {pc, word} pairs in a FIFO. Core redirects flush the FIFO.
// Options  : define PREFETCH_STATS_EN to add the fetch_stall_cnt output port
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0] fetch_stall_cnt
`endif
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
  localparam logic [1:0]      C_IDLE  = 2'd0;
  localparam logic [1:0]      C_REQ   = 2'd1;
  localparam logic [1:0]      C_WAIT  = 2'd2;
  localparam logic [1:0]      C_DROP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic          w_hs;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_after;
  logic          w_unused_redirect_lsbs;

  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

  assign w_hs          = mem_req_valid & mem_req_ready;
  assign w_pop         = inst_valid & inst_ready;
  assign w_push        = (state_q == C_WAIT) & mem_rsp_valid & ~redirect_valid;
  assign w_count_after = count_q + CW'(w_push) - CW'(w_pop);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= C_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a redirect overrides every normal transition
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      case (state_q)
        C_IDLE:  state_d = C_REQ;
        C_REQ:   state_d = w_hs ? C_DROP : C_REQ;
        // A response arriving with the redirect retires the stale fetch now
        default: state_d = mem_rsp_valid ? C_REQ : C_DROP;
      endcase
    end else begin
      case (state_q)
        C_IDLE:  state_d = (count_q < C_DEPTH) ? C_REQ : C_IDLE;
        C_REQ:   state_d = w_hs ? C_WAIT : C_REQ;
        C_WAIT:  if (mem_rsp_valid) state_d = (w_count_after < C_DEPTH) ? C_REQ : C_IDLE;
        default: if (mem_rsp_valid) state_d = C_REQ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    mem_req_valid = (state_q == C_REQ);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = w_count_after;
    wr_ptr_d   = wr_ptr_q + PW'(w_push);
    rd_ptr_d   = rd_ptr_q + PW'(w_pop);
    if (w_hs) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      data_mem_q[wr_ptr_q] <= mem_rsp_data;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign mem_req_addr = fetch_pc_q;
  assign inst_valid   = (count_q != '0);
  assign inst_data    = inst_valid ? data_mem_q[rd_ptr_q] : 32'd0;
  assign inst_pc      = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'd0;

`ifdef PREFETCH_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (inst_ready && !inst_valid && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch_buffer.sv
// ============================================================================
// Module   : tb_inst_prefetch_buffer
// Function : Randomized bench for inst_prefetch_buffer with a queue-based model
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef PREFETCH_STATS_EN
  logic [15:0] fetch_stall_cnt;
`endif

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef PREFETCH_STATS_EN
    ,
    .fetch_stall_cnt(fetch_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs (percent probabilities, response latency range)
  int p_ready = 100, p_iready = 100, p_rdr = 0, lat_min = 1, lat_max = 1;
  int rsp_cnt = 0;
  bit hs_seen = 0;
  bit force_rdr = 0, rdr_on_rsp = 0;
  logic [31:0] force_pc = '0;
  logic [31:0] hs_log[$];
  logic [31:0] pop_log[$];
  int cyc = 0, first_hs = -1, first_valid = -1;

  // Reference model: fetch phase flags plus a plain queue of {pc, word}
  bit          m_req, m_fly, m_stale;
  logic [31:0] m_pc, m_tag;
  logic [63:0] m_q[$];
  logic [15:0] m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s: got no event expected one (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    m_req = 0; m_fly = 0; m_stale = 0;
    m_pc = RESET_PC; m_tag = RESET_PC; m_stall = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    int sz0;
    bit hs, pop;
    sz0 = m_q.size();
    hs  = m_req && mem_req_ready;
    pop = (sz0 > 0) && inst_ready;
    if (inst_ready && sz0 == 0 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (pop) void'(m_q.pop_front());
    if (redirect_valid) begin
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if (m_fly) begin
        if (mem_rsp_valid) begin m_fly = 0; m_stale = 0; m_req = 1; end
        else m_stale = 1;
      end else if (hs) begin
        m_req = 0; m_fly = 1; m_stale = 1;
      end else begin
        m_req = 1;
      end
    end else if (m_req) begin
      if (hs) begin m_tag = m_pc; m_pc = m_pc + 32'd4; m_req = 0; m_fly = 1; m_stale = 0; end
    end else if (m_fly) begin
      if (mem_rsp_valid) begin
        if (!m_stale) m_q.push_back({m_tag, mem_rsp_data});
        m_req = m_stale || (m_q.size() < DEPTH);
        m_fly = 0; m_stale = 0;
      end
    end else begin
      m_req = (sz0 < DEPTH);
    end
  endtask

  task automatic drive();
    if (hs_seen) rsp_cnt = $urandom_range(lat_max, lat_min);
    hs_seen = 0;
    mem_rsp_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin mem_rsp_valid = 1'b1; mem_rsp_data = $urandom; end
    end
    mem_req_ready  = ($urandom_range(99, 0) < p_ready);
    inst_ready     = ($urandom_range(99, 0) < p_iready);
    redirect_valid = ($urandom_range(99, 0) < p_rdr);
    redirect_pc    = $urandom;
    if (force_rdr || (rdr_on_rsp && mem_rsp_valid)) begin
      redirect_valid = 1'b1; redirect_pc = force_pc;
      force_rdr = 0; rdr_on_rsp = 0;
    end
  endtask

  task automatic compare();
    chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, m_req});
    chk("mem_req_addr", mem_req_addr, m_pc);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      chk("inst_pc", inst_pc, m_q[0][63:32]);
      chk("inst_data", inst_data, m_q[0][31:0]);
    end
`ifdef PREFETCH_STATS_EN
    chk("fetch_stall_cnt", {16'd0, fetch_stall_cnt}, {16'd0, m_stall});
`endif
    if (mem_req_valid && mem_req_ready) begin
      hs_seen = 1;
      hs_log.push_back(mem_req_addr);
      if (first_hs < 0) first_hs = cyc;
    end
    if (inst_valid && first_valid < 0) first_valid = cyc;
    if (inst_valid && inst_ready) pop_log.push_back(inst_pc);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_step();
    #1;
    drive();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_logs();
    hs_log.delete(); pop_log.delete();
    first_hs = -1; first_valid = -1;
  endtask

  // Asserted away from the clock edge; outputs must drop immediately
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst mem_req_addr", mem_req_addr, RESET_PC);
    chk("rst inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst inst_data", inst_data, 32'd0);
    chk("rst inst_pc", inst_pc, 32'd0);
    model_reset();
    rsp_cnt = 0; hs_seen = 0; force_rdr = 0; rdr_on_rsp = 0;
    step();
    step();
    rst = 1'b1;
    clear_logs();
  endtask

  initial begin
    int n, idx;
    model_reset();
    do_reset();

    // Back-to-back fetch, single-cycle memory
    p_ready = 100; p_iready = 100; p_rdr = 0; lat_min = 1; lat_max = 1;
    n = 0;
    while (pop_log.size() < 4 && n < 60) begin step(); n++; end
    if (pop_log.size() < 4) timeout("first four pops");
    else begin
      chk("pop pc 0", pop_log[0], 32'h0);
      chk("pop pc 1", pop_log[1], 32'h4);
      chk("pop pc 2", pop_log[2], 32'h8);
      chk("pop pc 3", pop_log[3], 32'hC);
      chk("req addr 3", hs_log[3], 32'hC);
      chk("first valid latency", first_valid - first_hs, 32'd2);
    end

    // Consumer stalled: FIFO fills, then one pop opens exactly one fetch
    do_reset();
    p_iready = 0;
    repeat (30) step();
    chk("stalled req count", hs_log.size(), 32'd4);
    chk("stalled mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    hs_log.delete();
    p_iready = 100;
    step();
    p_iready = 0;
    repeat (8) step();
    chk("refill req count", hs_log.size(), 32'd1);

    // Redirect while waiting on a slow response
    do_reset();
    p_iready = 100; lat_min = 4; lat_max = 4;
    n = 0;
    while (!(!mem_req_valid && rsp_cnt >= 2) && n < 30) begin step(); n++; end
    if (n >= 30) timeout("reach wait");
    force_rdr = 1; force_pc = 32'h0000_0103;
    hs_log.delete();
    n = 0;
    while (hs_log.size() < 1 && n < 30) begin step(); n++; end
    if (hs_log.size() < 1) timeout("req after redirect");
    else chk("redirect addr", hs_log[0], 32'h0000_0100);
    pop_log.delete();
    n = 0;
    while (pop_log.size() < 1 && n < 30) begin step(); n++; end
    if (pop_log.size() < 1) timeout("pop after redirect");
    else chk("redirect pop pc", pop_log[0], 32'h0000_0100);

    // Redirect coinciding with the response
    do_reset();
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!(!mem_req_valid && rsp_cnt >= 1) && n < 30) begin step(); n++; end
    if (n >= 30) timeout("reach wait 2");
    rdr_on_rsp = 1; force_pc = 32'h0000_0040;
    hs_log.delete();
    n = 0;
    while (hs_log.size() < 1 && n < 30) begin step(); n++; end
    if (hs_log.size() < 1) timeout("req after rsp redirect");
    else chk("rsp redirect addr", hs_log[0], 32'h0000_0040);

    // Address wrap at the top of the space
    lat_min = 1; lat_max = 1;
    force_rdr = 1; force_pc = 32'hFFFF_FFFC;
    hs_log.delete();
    idx = -1; n = 0;
    while (idx < 0 && n < 40) begin
      step(); n++;
      for (int i = 0; i + 1 < hs_log.size(); i++)
        if (idx < 0 && hs_log[i] == 32'hFFFF_FFFC) idx = i;
    end
    if (idx < 0) timeout("wrap");
    else chk("wrap addr", hs_log[idx+1], 32'h0000_0000);

    // Reset pulse in the middle of a fetch
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!(!mem_req_valid && rsp_cnt >= 1) && n < 30) begin step(); n++; end
    if (n >= 30) timeout("reach wait 3");
    do_reset();

    // Randomized traffic
    for (int blk = 0; blk < 40; blk++) begin
      p_ready  = $urandom_range(100, 20);
      p_iready = $urandom_range(100, 0);
      p_rdr    = $urandom_range(10, 0);
      lat_min  = 1;
      lat_max  = $urandom_range(5, 1);
      repeat (100) step();
    end

`ifdef PREFETCH_STATS_EN
    do_reset();
    p_ready = 0; p_iready = 100; p_rdr = 0;
    repeat (70000) step();
    chk("stall saturate", {16'd0, fetch_stall_cnt}, 32'h0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
